countdown_timer_ctrl: RTL and testbench

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

---
 rtl/countdown_timer_ctrl.sv | 128 ++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// Seconds countdown timer: prescaled 1 Hz tick, start/pause/resume/clear control.
// Latency: commands act at the sampling edge; tick/done are registered, visible the cycle after.
// No backpressure: commands are level-sampled every edge, priority clear > start > pause.
`timescale 1ns/1ps

module countdown_timer_ctrl #(
  parameter int DIV   = 100000000,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic             tick,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             done
);

  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [CNT_W-1:0] remaining_nxt;
  logic             tick_nxt;
  logic             done_nxt;
  logic             pre_last;

  assign pre_last = (presc == PRE_LAST);

  // Next-state, prescaler and count update; command priority is clear > start > pause
  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    remaining_nxt = remaining;
    tick_nxt      = 1'b0;
    done_nxt      = 1'b0;

    if (clear) begin
      state_nxt     = IDLE;
      presc_nxt     = '0;
      remaining_nxt = '0;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (start) begin
            presc_nxt = '0;
            if (load_val != '0) begin
              remaining_nxt = load_val;
              state_nxt     = RUN;
            end else begin
              // Zero load expires immediately without ever ticking
              remaining_nxt = '0;
              state_nxt     = EXPIRED;
              done_nxt      = 1'b1;
            end
          end
        end
        RUN: begin
          if (pre_last) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            // Guarded compare so the count can never wrap below zero
            if (remaining <= CNT_W'(1)) begin
              remaining_nxt = '0;
              state_nxt     = EXPIRED;
              done_nxt      = 1'b1;
            end else begin
              remaining_nxt = remaining - CNT_W'(1);
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
          // start outranks pause even though start itself is a no-op in RUN;
          // expiry on the same edge wins over pausing
          if (!start && pause && (state_nxt == RUN)) begin
            state_nxt = PAUSE;
          end
        end
        PAUSE: begin
          // Prescaler keeps its held value so the partial second resumes
          if (start) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, prescaler, count and pulse registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      remaining <= remaining_nxt;
      tick      <= tick_nxt;
      done      <= done_nxt;
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl at DIV=4, CNT_W=16.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Flags vector order: {running, paused, expired, tick, done}.
`timescale 1ns/1ps

module tb_countdown_timer_ctrl;

  localparam int DIV   = 4;
  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             start;
  logic             pause;
  logic             clear;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] remaining;
  logic             tick;
  logic             running;
  logic             paused;
  logic             expired;
  logic             done;

  int n_vec = 0;
  int n_bad = 0;

  countdown_timer_ctrl #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .load_val  (load_val),
    .remaining (remaining),
    .tick      (tick),
    .running   (running),
    .paused    (paused),
    .expired   (expired),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({running, paused, expired, tick, done});
  endfunction

  // Steps until tick is seen (bounded) and checks how many edges that took
  task automatic tick_after(input string tag, input int n);
    int cnt  = 0;
    bit seen = 1'b0;
    while (!seen && cnt < n + 3) begin
      step();
      cnt++;
      if (tick) seen = 1'b1;
    end
    chk(tag, 32'(cnt), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load_val = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_flags", flags(), 32'b00000);
    chk("reset_rem", 32'(remaining), 32'd0);

    // Basic countdown from 3
    load_val = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_run", flags(), 32'b10000);
    chk("t1_rem_load", 32'(remaining), 32'd3);
    tick_after("t1_tick1_gap", 4);
    chk("t1_rem2", 32'(remaining), 32'd2);
    tick_after("t1_tick2_gap", 4);
    chk("t1_rem1", 32'(remaining), 32'd1);
    chk("t1_no_done", 32'(done), 32'd0);
    tick_after("t1_tick3_gap", 4);
    chk("t1_expire_flags", flags(), 32'b00111);
    chk("t1_rem0", 32'(remaining), 32'd0);
    step();
    chk("t1_expired_held", flags(), 32'b00100);
    step();
    step();
    chk("t1_done_no_repulse", flags(), 32'b00100);

    // Pause mid-second, hold, resume with partial prescale preserved
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t2_clear_flags", flags(), 32'b00000);
    load_val = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    tick_after("t2_tick1_gap", 4);
    chk("t2_rem4", 32'(remaining), 32'd4);
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t2_paused", flags(), 32'b01000);
    repeat (10) step();
    chk("t2_hold_flags", flags(), 32'b01000);
    chk("t2_hold_rem", 32'(remaining), 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_resumed", flags(), 32'b10000);
    tick_after("t2_resume_gap", 2);
    chk("t2_rem3", 32'(remaining), 32'd3);
    tick_after("t2_next_gap", 4);
    chk("t2_rem2", 32'(remaining), 32'd2);

    // Zero load expires immediately
    clear = 1'b1;
    step();
    clear = 1'b0;
    load_val = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_zero_flags", flags(), 32'b00101);
    chk("t3_zero_rem", 32'(remaining), 32'd0);
    step();
    chk("t3_zero_held", flags(), 32'b00100);

    // Pause on terminal count: tick still happens (start from EXPIRED)
    load_val = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t4_pause_tick", flags(), 32'b01010);
    chk("t4_pause_rem", 32'(remaining), 32'd1);
    step();
    chk("t4_paused_held", flags(), 32'b01000);
    start = 1'b1;
    step();
    start = 1'b0;
    tick_after("t4_resume_gap", 4);
    chk("t4_resume_expire", flags(), 32'b00111);
    clear = 1'b1;
    step();
    clear = 1'b0;
    load_val = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t4_pause_last_flags", flags(), 32'b00111);
    chk("t4_pause_last_rem", 32'(remaining), 32'd0);

    // start ignored in RUN; clear beats start on a terminal edge
    clear = 1'b1;
    step();
    clear = 1'b0;
    load_val = 16'd9; start = 1'b1;
    step();
    start = 1'b0;
    tick_after("t5_tick1_gap", 4);
    tick_after("t5_tick2_gap", 4);
    chk("t5_rem7", 32'(remaining), 32'd7);
    step();
    load_val = 16'd20; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_no_reload", 32'(remaining), 32'd7);
    chk("t5_still_run", flags(), 32'b10000);
    tick_after("t5_no_presc_clear", 2);
    chk("t5_rem6", 32'(remaining), 32'd6);
    step(); step(); step();
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    chk("t5_clear_flags", flags(), 32'b00000);
    chk("t5_clear_rem", 32'(remaining), 32'd0);
    step();
    chk("t5_clear_quiet", flags(), 32'b00000);

    // Reset mid-run beats start, then a fresh run
    load_val = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("t6_rst_flags", flags(), 32'b00000);
    chk("t6_rst_rem", 32'(remaining), 32'd0);
    load_val = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_run_rem", 32'(remaining), 32'd2);
    tick_after("t6_tick1_gap", 4);
    chk("t6_rem1", 32'(remaining), 32'd1);
    tick_after("t6_tick2_gap", 4);
    chk("t6_expire_flags", flags(), 32'b00111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
